// File: rtl/tybec_buf_pkg.sv
// Shared types and elaboration-time helpers for the stream tap buffer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package tybec_buf_pkg;

    // RUN accepts input; DRAIN flushes the bank after the last item of a stream.
    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Largest 8-bit offset among the first ntaps fields of a packed tap list.
    function automatic int max_tap(input int ntaps, input logic [63:0] taps);
        int m;
        m = 0;
        for (int k = 0; k < 8; k++) begin
            if (k < ntaps && int'(taps[8*k +: 8]) > m) begin
                m = int'(taps[8*k +: 8]);
            end
        end
        return m;
    endfunction

    // Ceiling log2 in a loop form that elaborates to a constant.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tybec_shift_bank.sv
// Data plus valid shift register; entry 0 is the newest.
// Latency: one cycle from shift_en to updated entries.
// Backpressure: none; holds its contents whenever shift_en is low.
// Ports: clk/rst (sync active-low, clears valid bits only), shift_en,
//        shin_dat/shin_vld (value entering entry 0), ent_dat/ent_vld (all entries).
module tybec_shift_bank #(
    parameter int W     = 34,
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      shift_en,
    input  logic [W-1:0]              shin_dat,
    input  logic                      shin_vld,
    output logic [DEPTH-1:0][W-1:0]   ent_dat,
    output logic [DEPTH-1:0]          ent_vld
);

    logic [DEPTH-1:0][W-1:0] dat_q, dat_d;
    logic [DEPTH-1:0]        vld_q, vld_d;

    always_comb begin
        dat_d = dat_q;
        vld_d = vld_q;
        if (shift_en) begin
            dat_d = {dat_q[DEPTH-2:0], shin_dat};
            vld_d = {vld_q[DEPTH-2:0], shin_vld};
        end
    end

    // Data entries carry no reset; the valid bits alone say what is live.
    always_ff @(posedge clk) begin
        dat_q <= dat_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign ent_dat = dat_q;
    assign ent_vld = vld_q;

endmodule

// File: rtl/tybec_stream_tap_buf.sv
// Multi-tap stream delay buffer with an optional end-of-stream drain phase.
// Latency: zero cycles; each tap presents its bank entry in the accepting cycle.
// Backpressure: iready is the AND of all oready bits and is held low while draining.
// Ports: clk, rst (sync active-low), ivalid/idata/ilast/iready (input stream),
//        ovalid/oready/odata/olast (one lane per tap), busy (high while draining).
module tybec_stream_tap_buf
    import tybec_buf_pkg::*;
#(
    parameter int                   STREAMW  = 34,
    parameter int                   SIZE     = 16,
    parameter int                   NTAPS    = 2,
    parameter logic [NTAPS*8-1:0]   TAPS     = {8'd16, 8'd4},
    parameter int                   DRAIN_EN = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ivalid,
    input  logic [STREAMW-1:0]         idata,
    input  logic                       ilast,
    output logic                       iready,
    output logic [NTAPS-1:0]           ovalid,
    input  logic [NTAPS-1:0]           oready,
    output logic [NTAPS*STREAMW-1:0]   odata,
    output logic [NTAPS-1:0]           olast,
    output logic                       busy
);

    localparam int MAXTAP = max_tap(NTAPS, 64'(TAPS));
    localparam int IDXW   = clog2(SIZE);

    state_t                      state_q;
    logic [7:0]                  dcnt_q;
    // Items accepted in the current stream, saturating; lets a tap whose window
    // never filled stay silent while the bank drains.
    logic [7:0]                  cnt_q;

    logic                        all_rdy;
    logic                        draining;
    logic                        fire;
    logic                        shift_en;
    logic [STREAMW-1:0]          shin_dat;
    logic [SIZE-1:0][STREAMW-1:0] ent_dat;
    logic [SIZE-1:0]             ent_vld;
    logic                        unused_bank;

    assign all_rdy  = &oready;
    assign draining = (state_q == DRAIN);
    assign iready   = all_rdy & ~draining;
    assign fire     = ivalid & iready;
    // While draining, zeros with cleared valid bits push the tail out of the bank.
    assign shift_en = fire | (draining & all_rdy);
    assign shin_dat = draining ? '0 : idata;
    assign busy     = draining;

    tybec_shift_bank #(
        .W     (STREAMW),
        .DEPTH (SIZE)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .shin_dat (shin_dat),
        .shin_vld (~draining),
        .ent_dat  (ent_dat),
        .ent_vld  (ent_vld)
    );

    // Bank bits that no tap reads are folded here so they are visibly intentional.
    assign unused_bank = ^{ent_dat, ent_vld};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            dcnt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (fire) begin
                        if (cnt_q != 8'hFF) begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                        if (ilast && DRAIN_EN != 0) begin
                            state_q <= DRAIN;
                            dcnt_q  <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (all_rdy) begin
                        if (dcnt_q == 8'(MAXTAP - 1)) begin
                            state_q <= RUN;
                            dcnt_q  <= '0;
                            cnt_q   <= '0;
                        end else begin
                            dcnt_q <= dcnt_q + 8'd1;
                        end
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    for (genvar k = 0; k < NTAPS; k++) begin : g_tap
        localparam logic [7:0]      OFF = TAPS[8*k +: 8];
        localparam logic [IDXW-1:0] IDX = IDXW'(OFF - 8'd1);
        logic tap_vld;

        assign tap_vld = ent_vld[IDX];
        assign odata[STREAMW*k +: STREAMW] = ent_dat[IDX];
        assign ovalid[k] = draining ? (tap_vld & all_rdy & (cnt_q >= OFF))
                                    : (tap_vld & fire);
        assign olast[k]  = ovalid[k] & draining & (dcnt_q == OFF - 8'd1);
    end

endmodule
